// File: rtl/udp_chk_pkg.sv
// Shared types and constants for the primitive response checker.
package udp_chk_pkg;

  localparam int unsigned CW_DEF = 16;

  // first_err value meaning "no mismatch seen yet"
  localparam logic [CW_DEF-1:0] STAMP_NONE = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_CHECK,
    ST_DONE
  } chk_state_t;

endpackage

// File: rtl/udp_chk_delay.sv
// Aligns {valid,bit} of the stimulus with the primitive outputs by LATENCY cycles.
module udp_chk_delay #(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] stage_in,
  output logic [1:0] aligned
);

  logic [1:0] pipe [LATENCY];

  // shift one stage per cycle, independent of checker state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= stage_in;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign aligned = pipe[LATENCY-1];

endmodule

// File: rtl/udp_resp_checker.sv
// Compares true/inverted primitive outputs against the delayed stimulus bit,
// counts mismatches and reports done/pass/fail.
//
// state     | meaning
// ST_IDLE   | waiting for start
// ST_WARMUP | discarding the first WARMUP aligned samples
// ST_CHECK  | comparing aligned samples, counting mismatches
// ST_DONE   | result frozen until start or rst
module udp_resp_checker
  import udp_chk_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int WARMUP  = 1,
  parameter int NCHECK  = 89,
  parameter int MAX_ERR = 1,
  parameter int CW      = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stim_valid,
  input  logic          stim_bit,
  input  logic          obs_true,
  input  logic          obs_comp,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic [CW-1:0] err_cnt,
  output logic [CW-1:0] chk_cnt,
  output logic [CW-1:0] first_err
);

  localparam logic [CW-1:0] NONE      = {CW{STAMP_NONE[0]}};
  localparam logic [CW-1:0] ERR_LIMIT = CW'(MAX_ERR);
  localparam logic [CW-1:0] CHK_LIMIT = CW'(NCHECK);

  chk_state_t    state;
  logic [7:0]    skip_cnt;
  logic [1:0]    aligned;
  logic          a_vld;
  logic          a_bit;
  logic          mismatch;
  logic [CW-1:0] chk_next;
  logic [CW-1:0] err_next;

  udp_chk_delay #(.LATENCY(LATENCY)) u_delay (
    .clk      (clk),
    .rst      (rst),
    .stage_in ({stim_valid, stim_bit}),
    .aligned  (aligned)
  );

  assign a_vld    = aligned[1];
  assign a_bit    = aligned[0];
  assign mismatch = (obs_true != a_bit) | (obs_comp != ~a_bit);
  assign chk_next = chk_cnt + 1'b1;
  assign err_next = (err_cnt == NONE) ? err_cnt : err_cnt + 1'b1;

  // run sequencing, counters and registered result flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      skip_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      err_cnt   <= '0;
      chk_cnt   <= '0;
      first_err <= NONE;
    end else if (start) begin
      // start from any state re-arms; an aborted run never reports done
      state     <= (WARMUP > 0) ? ST_WARMUP : ST_CHECK;
      skip_cnt  <= 8'(WARMUP);
      busy      <= 1'b1;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      err_cnt   <= '0;
      chk_cnt   <= '0;
      first_err <= NONE;
    end else begin
      case (state)
        ST_WARMUP: begin
          if (a_vld) begin
            skip_cnt <= skip_cnt - 1'b1;
            if (skip_cnt == 8'd1) state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (a_vld) begin
            chk_cnt <= chk_next;
            if (mismatch) begin
              err_cnt <= err_next;
              if (err_cnt == '0) first_err <= chk_cnt;
            end
            if ((mismatch && err_next >= ERR_LIMIT) || chk_next == CHK_LIMIT) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= ~mismatch & (err_cnt == '0);
              fail  <= mismatch | (err_cnt != '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
